// File: rtl/uart_rx_buffer_ctrl_pkg.sv
// Shared types and defaults for the UART receive buffer controller.
// Optional macro UART_RX_DROP_PARITY_ERR_EN is consumed by uart_rx_buffer_ctrl.
package uart_rx_buffer_ctrl_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 16;
    localparam int unsigned UART_RX_TIMEOUT_DEFAULT = 4096;

    typedef logic [UART_DATA_W-1:0] uart_data_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        TIMEOUT = 2'd2
    } uart_rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_buffer_ctrl_if.sv
// Ready/valid character handshake between the UART receiver (master) and the
// receive buffer controller (slave).
interface uart_rx_buffer_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] rx_data;
    logic              rx_data_valid;
    logic              parity_error;
    logic              rx_data_ready;

    modport master (
        output rx_data,
        output rx_data_valid,
        output parity_error,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        input  parity_error,
        output rx_data_ready
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Storage, pointers and occupancy for the receive FIFO; head is presented
// first-word-fall-through and reads as zero while empty.
module uart_rx_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              wr_en;
    logic              rd_en;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = empty ? '0 : mem[rd_ptr_q];

    // Guarded again here so the FIFO stays consistent whatever the caller does.
    assign wr_en = push && !full && !clear;
    assign rd_en = pop && !empty && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive buffer controller: FIFO backpressure, idle-timeout FSM, threshold
// interrupt and error tracking. Macro UART_RX_DROP_PARITY_ERR_EN drops bad characters.
module uart_rx_buffer_ctrl
    import uart_rx_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = $bits(uart_data_t),
    parameter int unsigned DEPTH          = UART_RX_FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = UART_RX_TIMEOUT_DEFAULT,
    parameter int unsigned LVL_W          = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_buffer_ctrl_if.slave rx,
    input  logic                 host_rd_en,
    output logic [DATA_W-1:0]    host_rd_data,
    output logic                 host_empty,
    output logic [LVL_W-1:0]     level,
    input  logic [LVL_W-1:0]     thresh,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic                 irq_thresh,
    output logic                 irq_timeout,
    output logic                 stall_sticky,
    output logic [7:0]           parity_err_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    uart_rx_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic                stall_q, stall_d;
    logic [7:0]          perr_cnt_q, perr_cnt_d;
    logic                irq_thresh_q, irq_thresh_d;

    logic full;
    logic empty;
    logic ready;
    logic accept;
    logic store;
    logic pop;
    logic activity;
    logic drain;

    // Ready depends only on registered occupancy and flush, never on host_rd_en.
    assign ready            = !full && !flush;
    assign rx.rx_data_ready = ready;
    assign accept           = rx.rx_data_valid && ready;
    assign pop              = host_rd_en && !empty && !flush;

`ifdef UART_RX_DROP_PARITY_ERR_EN
    assign store = accept && !rx.parity_error;
`else
    assign store = accept;
`endif

    assign activity = store || pop;
    assign drain    = pop && !store && (level == LVL_W'(1));

    uart_rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store),
        .wdata (rx.rx_data),
        .pop   (pop),
        .clear (flush),
        .rdata (host_rd_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign host_empty = empty;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        if (flush) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_d = '0;
                    if (store) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (activity) begin
                        tmo_d = '0;
                        if (drain) begin
                            state_d = IDLE;
                        end
                    end else if (tmo_q == CNT_MAX) begin
                        state_d = TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + CNT_W'(1);
                    end
                end
                TIMEOUT: begin
                    if (activity) begin
                        tmo_d   = '0;
                        state_d = drain ? IDLE : ACTIVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    // err_clr wins over any same-cycle stall or parity event.
    always_comb begin
        stall_d    = stall_q;
        perr_cnt_d = perr_cnt_q;
        if (err_clr) begin
            stall_d    = 1'b0;
            perr_cnt_d = '0;
        end else begin
            if (rx.rx_data_valid && !ready) begin
                stall_d = 1'b1;
            end
            if (accept && rx.parity_error && (perr_cnt_q != 8'hFF)) begin
                perr_cnt_d = perr_cnt_q + 8'd1;
            end
        end
    end

    assign irq_thresh_d = (thresh != '0) && (level >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            stall_q      <= 1'b0;
            perr_cnt_q   <= '0;
            irq_thresh_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            stall_q      <= stall_d;
            perr_cnt_q   <= perr_cnt_d;
            irq_thresh_q <= irq_thresh_d;
        end
    end

    assign irq_timeout    = (state_q == TIMEOUT);
    assign irq_thresh     = irq_thresh_q;
    assign stall_sticky   = stall_q;
    assign parity_err_cnt = perr_cnt_q;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Self-checking bench for uart_rx_buffer_ctrl: directed steps plus randomized traffic
// against a queue-based reference model. Honours UART_RX_DROP_PARITY_ERR_EN.
module tb_uart_rx_buffer_ctrl;
    import uart_rx_buffer_ctrl_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 8;
    localparam int unsigned LVL_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             host_rd_en;
    logic [7:0]       host_rd_data;
    logic             host_empty;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] thresh;
    logic             flush;
    logic             err_clr;
    logic             irq_thresh;
    logic             irq_timeout;
    logic             stall_sticky;
    logic [7:0]       parity_err_cnt;

    always #5 clk = ~clk;

    uart_rx_buffer_ctrl_if #(.DATA_W(8)) rx_if ();

    uart_rx_buffer_ctrl #(
        .DATA_W         (8),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .LVL_W          (LVL_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx_if.slave),
        .host_rd_en     (host_rd_en),
        .host_rd_data   (host_rd_data),
        .host_empty     (host_empty),
        .level          (level),
        .thresh         (thresh),
        .flush          (flush),
        .err_clr        (err_clr),
        .irq_thresh     (irq_thresh),
        .irq_timeout    (irq_timeout),
        .stall_sticky   (stall_sticky),
        .parity_err_cnt (parity_err_cnt)
    );

    // Reference model: stored characters, error state, idle cycles with data held.
    logic [7:0] mq[$];
    int         m_cnt;
    bit         m_sticky;
    bit         m_ithr;
    int         m_idle;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("level", 32'(level), mq.size());
        chk("host_empty", 32'(host_empty), 32'(mq.size() == 0));
        chk("host_rd_data", 32'(host_rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("irq_thresh", 32'(irq_thresh), 32'(m_ithr));
        chk("irq_timeout", 32'(irq_timeout), 32'(m_idle >= int'(TMO)));
        chk("stall_sticky", 32'(stall_sticky), 32'(m_sticky));
        chk("parity_err_cnt", 32'(parity_err_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
        m_ithr   = 1'b0;
        m_idle   = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(rx_if.rx_data_ready), 32'd1);
        chk({tag, "_empty"}, 32'(host_empty), 32'd1);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_rd_data"}, 32'(host_rd_data), 32'd0);
        chk({tag, "_irq_thresh"}, 32'(irq_thresh), 32'd0);
        chk({tag, "_irq_timeout"}, 32'(irq_timeout), 32'd0);
        chk({tag, "_sticky"}, 32'(stall_sticky), 32'd0);
        chk({tag, "_perr_cnt"}, 32'(parity_err_cnt), 32'd0);
    endtask

    // One clock of stimulus: drive, check ready, advance model, clock, check outputs.
    task automatic step(input bit v, input uart_data_t d, input bit pe, input bit rd,
                        input bit fl, input bit ec);
        bit exp_ready;
        bit acc;
        bit pop;
        bit st;
        int sz;
        rx_if.rx_data_valid = v;
        rx_if.rx_data       = d;
        rx_if.parity_error  = pe;
        host_rd_en          = rd;
        flush               = fl;
        err_clr             = ec;
        #1;
        sz        = mq.size();
        exp_ready = (sz != int'(DEPTH)) && !fl;
        chk("rx_data_ready", 32'(rx_if.rx_data_ready), 32'(exp_ready));
        acc = v && exp_ready;
        pop = rd && (sz != 0) && !fl;
        st  = acc;
`ifdef UART_RX_DROP_PARITY_ERR_EN
        st = acc && !pe;
`endif
        m_ithr = (thresh != 0) && (sz >= int'(thresh));
        if (ec) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else begin
            if (v && !exp_ready) m_sticky = 1'b1;
            if (acc && pe && m_cnt < 255) m_cnt++;
        end
        if (fl) begin
            mq.delete();
            m_idle = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (st) mq.push_back(d);
            if (mq.size() == 0 || pop || st) m_idle = 0;
            else m_idle++;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic push(input uart_data_t d, input bit pe);
        step(1'b1, d, pe, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic random_steps(input int n, input int pv, input int pr);
        for (int i = 0; i < n; i++) begin
            if (i % 50 == 49) begin
                for (int k = 0; k < 10; k++) idle();
            end
            step(($urandom % 100) < pv, uart_data_t'($urandom), ($urandom % 4) == 0,
                 ($urandom % 100) < pr, ($urandom % 64) == 0, ($urandom % 32) == 0);
        end
    endtask

    initial begin
        rx_if.rx_data_valid = 1'b0;
        rx_if.rx_data       = '0;
        rx_if.parity_error  = 1'b0;
        host_rd_en          = 1'b0;
        flush               = 1'b0;
        err_clr             = 1'b0;
        thresh              = '0;
        rst_n               = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // In-order delivery with FWFT head.
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        idle();
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_head", 32'(host_rd_data), 32'h41);
        pop_one();
        pop_one();
        pop_one();
        chk("t1_empty", 32'(host_empty), 32'd1);

        // Fill to DEPTH, stall, then one pop frees a slot for the next cycle.
        for (int i = 0; i < 16; i++) push(uart_data_t'(8'h60 + i), 1'b0);
        chk("t2_level16", 32'(level), 32'd16);
        chk("t2_ready_full", 32'(rx_if.rx_data_ready), 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_sticky", 32'(stall_sticky), 32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_refill", 32'(level), 32'd16);
        do_flush();

        // Threshold interrupt lags level by one cycle.
        thresh = 5'd4;
        for (int i = 0; i < 4; i++) push(uart_data_t'(8'h20 + i), 1'b0);
        chk("t3_irq_lag", 32'(irq_thresh), 32'd0);
        idle();
        chk("t3_irq_set", 32'(irq_thresh), 32'd1);
        pop_one();
        idle();
        chk("t3_irq_clr", 32'(irq_thresh), 32'd0);
        thresh = '0;
        do_flush();

        // Idle timeout fires exactly TMO cycles after the push.
        push(8'h55, 1'b0);
        for (int i = 0; i < int'(TMO) - 1; i++) idle();
        chk("t4_not_yet", 32'(irq_timeout), 32'd0);
        idle();
        chk("t4_timeout", 32'(irq_timeout), 32'd1);
        pop_one();
        chk("t4_cleared", 32'(irq_timeout), 32'd0);
        chk("t4_empty", 32'(host_empty), 32'd1);

        // Parity errors counted; storage depends on the drop option.
        for (int i = 0; i < 3; i++) push(uart_data_t'(8'hA0 + i), 1'b1);
        idle();
        chk("t5_perr_cnt", 32'(parity_err_cnt), 32'd3);
`ifdef UART_RX_DROP_PARITY_ERR_EN
        chk("t5_level", 32'(level), 32'd0);
`else
        chk("t5_level", 32'(level), 32'd3);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_err_clr", 32'(parity_err_cnt), 32'd0);
        do_flush();

        // Flush blocks a same-cycle push and pop.
        for (int i = 0; i < 5; i++) push(uart_data_t'(8'h90 + i), 1'b0);
        chk("t6_level5", 32'(level), 32'd5);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_flush_level", 32'(level), 32'd0);
        chk("t6_flush_cnt", 32'(parity_err_cnt), 32'd0);

        // Randomized traffic, fill-biased then drain-biased.
        thresh = LVL_W'($urandom_range(0, 16));
        random_steps(200, 70, 20);
        thresh = LVL_W'($urandom_range(0, 16));
        random_steps(200, 25, 45);

        // Asynchronous reset mid-stream with the receiver still presenting data.
        for (int i = 0; i < 4; i++) push(uart_data_t'($urandom), 1'b1);
        rx_if.rx_data_valid = 1'b1;
        flush               = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model();

        thresh = LVL_W'($urandom_range(1, 16));
        random_steps(150, 50, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer_ctrl.md
Name: uart_rx_buffer_ctrl

Overview:
Receive-side controller that drains the UART receiver through its ready/valid handshake into a DEPTH-entry FIFO for the host. It applies backpressure to the receiver and counts parity errors. It raises a level-threshold interrupt and an idle-timeout interrupt, and flags receiver stalls. It sits between the UART receiver outputs and the host/CSR read path.

Parameters:
- DATA_W, 8, width of one received character; must match uart_data_t.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 4096, idle clock cycles with data buffered before irq_timeout asserts; >= 2.
- LVL_W, $clog2(DEPTH)+1, width of level and thresh (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- rx_data  in  DATA_W  character from the UART receiver.
- rx_data_valid  in  1  rx_data is valid.
- parity_error  in  1  parity-error qualifier for the current rx_data; sampled only on accept.
- rx_data_ready  out  1  controller can accept a character.
- host_rd_en  in  1  pop request from the host.
- host_rd_data  out  DATA_W  head of FIFO, first-word-fall-through.
- host_empty  out  1  FIFO empty.
- level  out  LVL_W  current occupancy, 0..DEPTH.
- thresh  in  LVL_W  interrupt threshold; 0 disables irq_thresh.
- flush  in  1  synchronous FIFO clear.
- err_clr  in  1  clears stall_sticky and parity_err_cnt.
- irq_thresh  out  1  level >= thresh and thresh != 0.
- irq_timeout  out  1  idle timeout pending.
- stall_sticky  out  1  the receiver was held off at least once.
- parity_err_cnt  out  8  saturating count of accepted characters with parity_error.

Behaviour:
- Reset values:
  - rx_data_ready=1, host_empty=1, level=0, host_rd_data=0.
  - irq_thresh=0, irq_timeout=0, stall_sticky=0, parity_err_cnt=0.
  - State IDLE, pointers 0, timeout counter 0.
- Accept (push):
  - A character is accepted when rx_data_valid && rx_data_ready.
  - rx_data_ready = !full && !flush.
  - An accepted character appears on host_rd_data one cycle later if the FIFO was empty.
- Pop:
  - host_rd_en && !host_empty removes the head; level decrements next cycle.
  - host_rd_en while empty is ignored with no side effect.
- Simultaneous push and pop: both occur and level is unchanged. When full, a pop frees space for the next cycle only; ready is not combinationally dependent on host_rd_en.
- Pointers wrap modulo DEPTH. Full is level==DEPTH, empty is level==0.
- stall_sticky sets on any cycle with rx_data_valid && !rx_data_ready.
- parity_err_cnt:
  - Increments on accept with parity_error=1 and saturates at 255.
  - err_clr has priority over set/increment; a same-cycle event is lost.
- flush:
  - Pointers and level go to 0, state goes to IDLE, and the timeout counter clears.
  - Counters and stall_sticky are kept.
  - A same-cycle push is blocked (ready=0); a same-cycle pop is ignored.
- irq_thresh is a registered compare: it updates the cycle after a level or thresh change.
- FSM (enum in package):
  - IDLE: FIFO empty, counter held at 0. A push moves to ACTIVE.
  - ACTIVE: the counter increments each cycle with no push and no pop; a push or pop resets it to 0. Counter == TIMEOUT_CYCLES-1 moves to TIMEOUT. A pop emptying the FIFO (no same-cycle push) moves to IDLE.
  - TIMEOUT: irq_timeout=1. A pop or push moves to ACTIVE (or to IDLE if empty after a pop) and clears the counter.
  - flush from any state moves to IDLE.
- Reset mid-character: all state is discarded; the receiver sees ready=1 after reset.

Optional Feature:
- Macro UART_RX_DROP_PARITY_ERR_EN.
- Defined: a character with parity_error=1 is handshaken (ready obeys the normal rule) but not written; level and the timeout counter are unchanged; parity_err_cnt still increments.
- Undefined: all accepted characters are stored regardless of parity_error.

Decomposition:
- UART_pkg gets:
  - uart_rx_ctrl_state_e {IDLE, ACTIVE, TIMEOUT};
  - UART_RX_FIFO_DEPTH_DEFAULT=16;
  - UART_RX_TIMEOUT_DEFAULT=4096.
- Reuse uart_data_t for the data width.
- One sub-module, uart_rx_fifo_mem, holds storage, pointers, level, full/empty and FWFT read. The FSM, timeout, counters and interrupts live in the top.

Test Plan:
1. Push 0x41,0x42,0x43 with no reads -> level=3, host_rd_data=0x41. Three pops return 0x41,0x42,0x43 in order; host_empty=1 afterwards.
2. Push 16 characters with valid held high on the 17th -> rx_data_ready=0 at level 16, stall_sticky=1. One pop -> the 17th is accepted the following cycle and level returns to 16.
3. thresh=4, push 4 -> irq_thresh=1 the cycle after level reaches 4. One pop -> irq_thresh=0.
4. TIMEOUT_CYCLES=8, push 1 and wait -> irq_timeout=1 exactly 8 cycles after the push. Pop -> irq_timeout=0, state IDLE.
5. Push 3 characters with parity_error=1 -> parity_err_cnt=3 and level=3 (macro off) or level=0 (macro on). err_clr -> cnt=0.
6. Level=5 with flush and valid asserted in the same cycle -> level=0, the push is not taken, parity_err_cnt unchanged. Also assert rst_n low mid-stream -> all outputs return to their reset values asynchronously.
